// File: rtl/crc16_pkg.sv
// Shared constants and FSM state encoding for the CRC16 frame transmitter.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY         = 16'h8005;
  localparam logic [15:0] CRC16_INIT_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC_HI  = 2'd2,
    CRC_LO  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/crc16_byte_step.sv
// One-byte CRC16 update: MSB-first, no reflection, polynomial from crc16_pkg.
module crc16_byte_step
  import crc16_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  // Fold the byte into the top of the register, then run eight shift/XOR steps.
  always_comb begin
    logic [15:0] c;
    c = crc_i ^ {data_i, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else       c = {c[14:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc16_frame_tx.sv
// Frame transmitter: forwards payload bytes with one cycle of latency, then
// appends the CRC16 (high byte, then low byte flagged with m_last).
module crc16_frame_tx
  import crc16_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = CRC16_INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] frame_cnt
);

  tx_state_e   state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] crc_step;
  logic        slot_free;
  logic        s_fire;

  // The output register can take a new byte when empty or being drained now.
  assign slot_free = !m_valid_q || m_ready;
  assign s_ready   = rst_n && slot_free && ((state_q == IDLE) || (state_q == PAYLOAD));
  assign s_fire    = s_valid && s_ready;

  crc16_byte_step u_step (
    .crc_i  (crc_q),
    .data_i (s_data),
    .crc_o  (crc_step)
  );

  // State, CRC accumulator, output register and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= CRC_INIT;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic: load payload, then CRC high, then CRC low into the output slot.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    frame_cnt_d = frame_cnt_q;

    // A drained slot empties unless something below refills it this cycle.
    if (slot_free) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE, PAYLOAD: begin
        if (s_fire) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = crc_step;
          state_d   = s_last ? CRC_HI : PAYLOAD;
        end
      end
      CRC_HI: begin
        if (slot_free) begin
          m_data_d  = crc_q[15:8];
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          state_d   = CRC_LO;
        end
      end
      CRC_LO: begin
        if (slot_free) begin
          m_data_d    = crc_q[7:0];
          m_valid_d   = 1'b1;
          m_last_d    = 1'b1;
          crc_d       = CRC_INIT;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Directed bench for crc16_frame_tx: table of frames with hand-computed CRCs,
// plus sequences for back-to-back framing, mid-frame reset and counter wrap.
module tb_crc16_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  crc16_frame_tx #(.CRC_INIT(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [71:0] pay;   // first byte in bits [71:64]
    int          len;
    logic [15:0] crc;
    bit          stall;
  } frame_vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          stall_en = 1'b0;
  logic [15:0] cnt_exp;
  beat_t       out_q[$];
  int          last_cyc_q[$];
  frame_vec_t  vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: random back-pressure when enabled, otherwise always ready.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: collects transferred beats and checks hold-while-stalled.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        check("hold_under_stall", {23'd0, m_valid, m_last, m_data}, {23'd0, 1'b1, prev_last, prev_data});
      if (m_valid && m_ready) out_q.push_back(beat_t'{m_data, m_last});
      if (m_valid && m_last) last_cyc_q.push_back(cyc);
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end
  end

  task automatic send_frame(input logic [71:0] pay, input int len, input bit term,
                            output int first_cyc, output int last_cyc);
    first_cyc = -1;
    last_cyc  = -1;
    for (int i = 0; i < len; i++) begin
      int waited;
      bit acc;
      s_valid = 1'b1;
      s_data  = pay[71-8*i -: 8];
      s_last  = term && (i == len - 1);
      acc     = 1'b0;
      waited  = 0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        if (s_ready) begin
          acc = 1'b1;
          if (i == 0) first_cyc = cyc;
          last_cyc = cyc;
        end
        @(posedge clk);
        #1;
        waited++;
      end
      check("s_accept", {31'd0, acc}, 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'hA5;   // junk while idle; must not reach the CRC
  endtask

  task automatic expect_frame(input logic [71:0] pay, input int len, input logic [15:0] crc, input int id);
    int w;
    int got;
    w = 0;
    while (out_q.size() < len + 2 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    got = (out_q.size() > len + 2) ? len + 2 : out_q.size();
    check("beat_count", got, len + 2);
    for (int i = 0; i < got; i++) begin
      beat_t      b;
      logic [7:0] exp_d;
      b = out_q.pop_front();
      if (i < len)       exp_d = pay[71-8*i -: 8];
      else if (i == len) exp_d = crc[15:8];
      else               exp_d = crc[7:0];
      check("m_data", {24'd0, b.data}, {24'd0, exp_d});
      check("m_last", {31'd0, b.last}, {31'd0, (i == len + 1)});
    end
    $display("frame %0d: %0d payload bytes, crc expected %04h, %0d beats seen", id, len, crc, got);
  endtask

  initial begin
    int f0, l0, f1, l1;
    frame_vec_t v;

    vecs[0] = '{72'h313233343536373839, 9, 16'hFEE8, 1'b0};
    vecs[1] = '{72'h010000000000000000, 1, 16'h8005, 1'b0};
    vecs[2] = '{72'h310000000000000000, 1, 16'h80A5, 1'b0};
    vecs[3] = '{72'h313233343536373839, 9, 16'hFEE8, 1'b1};
    vecs[4] = '{72'h000000000000000000, 1, 16'h0000, 1'b0};
    vecs[5] = '{72'h800000000000000000, 1, 16'h8303, 1'b0};
    vecs[6] = '{72'h010000000000000000, 2, 16'h8603, 1'b0};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'hA5;
    cnt_exp = 16'h0000;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table of frames.
    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      stall_en = v.stall;
      send_frame(v.pay, v.len, 1'b1, f0, l0);
      if (!v.stall) check("payload_rate", l0 - f0, v.len - 1);
      expect_frame(v.pay, v.len, v.crc, k);
      stall_en = 1'b0;
      cnt_exp++;
      @(negedge clk);
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, cnt_exp});
      check("m_valid_idle", {31'd0, m_valid}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Back-to-back: "1" then "123456789" with s_valid held high.
    last_cyc_q.delete();
    send_frame(72'h310000000000000000, 1, 1'b1, f0, l0);
    send_frame(72'h313233343536373839, 9, 1'b1, f1, l1);
    expect_frame(72'h310000000000000000, 1, 16'h80A5, 100);
    expect_frame(72'h313233343536373839, 9, 16'hFEE8, 101);
    check("b2b_gap", f1, (last_cyc_q.size() > 0) ? last_cyc_q[0] : -1);
    cnt_exp += 16'd2;
    check("b2b_frame_cnt", {16'd0, frame_cnt}, {16'd0, cnt_exp});

    // Reset after the 4th payload byte, then a clean frame.
    send_frame(72'h313233340000000000, 4, 1'b0, f0, l0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    @(posedge clk);
    #1;
    out_q.delete();
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_residue", out_q.size(), 0);
    cnt_exp = 16'h0000;
    send_frame(72'h313233343536373839, 9, 1'b1, f0, l0);
    expect_frame(72'h313233343536373839, 9, 16'hFEE8, 200);
    cnt_exp++;
    check("midrst_frame_cnt_after", {16'd0, frame_cnt}, {16'd0, cnt_exp});

    // Counter wrap: preset as if 65535 frames had completed, then one more.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    @(negedge clk);
    cnt_exp = 16'hFFFF;
    check("wrap_preset", {16'd0, frame_cnt}, {16'd0, cnt_exp});
    @(posedge clk);
    #1;
    send_frame(72'h010000000000000000, 1, 1'b1, f0, l0);
    expect_frame(72'h010000000000000000, 1, 16'h8005, 300);
    cnt_exp++;
    check("wrap_frame_cnt", {16'd0, frame_cnt}, {16'd0, cnt_exp});

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
